// File: rtl/regfile_port_arbiter_if.sv
// Debug/UART requester handshake into the register-file port arbiter.
// The requester drives the request fields; the arbiter returns ack, read data and busy.
interface regfile_port_arbiter_if;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_busy;

    modport master (
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata, dbg_busy
    );

    modport slave (
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata, dbg_busy
    );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Shares the regfile write port and rs1 read port between the pipeline and a debug requester.
// Writeback always wins; a debug write steals an idle slot or, after STARVE_LIMIT cycles, stalls the pipe.
module regfile_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic [4:0]  id_rs1_adr,
    input  logic [31:0] rf_rs1_data,
    regfile_port_arbiter_if.slave dbg,
    output logic        rf_wen,
    output logic [4:0]  rf_wadr,
    output logic [31:0] rf_wdata,
    output logic [4:0]  rf_rs1_adr,
    output logic        pipe_stall
);

    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STARVE_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        slot_free;
    logic        dbg_wr;
    logic        rs1_steal;

    assign slot_free = !wb_regwrite || (wb_rd == 5'd0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        dbg_wr    = 1'b0;
        rs1_steal = 1'b0;

        case (state_q)
            IDLE: begin
                if (dbg.dbg_req) begin
                    we_d    = dbg.dbg_we;
                    addr_d  = dbg.dbg_addr;
                    wdata_d = dbg.dbg_wdata;
                    cnt_d   = '0;
                    state_d = dbg.dbg_we ? WAIT : STALL;
                end
            end
            WAIT: begin
                if (slot_free) begin
                    dbg_wr  = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STALL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STALL: begin
                rs1_steal = !we_q;
                // Pipeline is frozen but in-flight writeback must drain before we take the port.
                if (slot_free) begin
                    if (we_q) begin
                        dbg_wr = 1'b1;
                    end else begin
                        rdata_d = (addr_q == 5'd0) ? 32'd0 : rf_rs1_data;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 5'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Debug access is suppressed while Rst is high so an abandoned request never reaches the regfile.
    always_comb begin
        if (dbg_wr && !Rst) begin
            rf_wen   = (addr_q != 5'd0);
            rf_wadr  = addr_q;
            rf_wdata = wdata_q;
        end else begin
            rf_wen   = wb_regwrite && (wb_rd != 5'd0);
            rf_wadr  = wb_rd;
            rf_wdata = wb_data;
        end
    end

    assign rf_rs1_adr    = (rs1_steal && !Rst) ? addr_q : id_rs1_adr;
    assign pipe_stall    = (state_q == STALL);
    assign dbg.dbg_ack   = (state_q == RESP);
    assign dbg.dbg_busy  = (state_q != IDLE);
    assign dbg.dbg_rdata = rdata_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter: passthrough table plus hand-built debug sequences.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        Rst;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  id_rs1_adr;
    logic [31:0] rf_rs1_data;
    logic        rf_wen;
    logic [4:0]  rf_wadr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_rs1_adr;
    logic        pipe_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter_if dif ();

    regfile_port_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk         (clk),
        .Rst         (Rst),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .id_rs1_adr  (id_rs1_adr),
        .rf_rs1_data (rf_rs1_data),
        .dbg         (dif),
        .rf_wen      (rf_wen),
        .rf_wadr     (rf_wadr),
        .rf_wdata    (rf_wdata),
        .rf_rs1_adr  (rf_rs1_adr),
        .pipe_stall  (pipe_stall)
    );

    // Register file read model: x7 holds 0x12345678, x0 returns junk so the DUT must zero it.
    assign rf_rs1_data = (rf_rs1_adr == 5'd7) ? 32'h1234_5678 :
                         (rf_rs1_adr == 5'd0) ? 32'hFFFF_FFFF :
                         {27'h0A5_0000, rf_rs1_adr};

    typedef struct {
        logic        wbw;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs1;
        logic        exp_wen;
        logic [4:0]  exp_wadr;
        logic [31:0] exp_wdata;
        logic [4:0]  exp_rs1;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic request(input logic we, input logic [4:0] a, input logic [31:0] d);
        dif.dbg_req   = 1'b1;
        dif.dbg_we    = we;
        dif.dbg_addr  = a;
        dif.dbg_wdata = d;
        nxt();
        dif.dbg_req = 1'b0;
        #1;
    endtask

    initial begin
        logic [4:0] exp_ack;
        logic [4:0] exp_busy;
        logic [4:0] exp_wen;

        tbl[0] = '{1'b1, 5'd3,  32'hAAAA_0003, 5'd9,  1'b1, 5'd3,  32'hAAAA_0003, 5'd9};
        tbl[1] = '{1'b1, 5'd0,  32'h1111_0000, 5'd1,  1'b0, 5'd0,  32'h1111_0000, 5'd1};
        tbl[2] = '{1'b0, 5'd12, 32'h2222_000C, 5'd31, 1'b0, 5'd12, 32'h2222_000C, 5'd31};
        tbl[3] = '{1'b1, 5'd31, 32'hFFFF_0000, 5'd0,  1'b1, 5'd31, 32'hFFFF_0000, 5'd0};
        tbl[4] = '{1'b0, 5'd0,  32'h0,         5'd7,  1'b0, 5'd0,  32'h0,         5'd7};

        Rst           = 1'b1;
        wb_regwrite   = 1'b0;
        wb_rd         = 5'd0;
        wb_data       = 32'd0;
        id_rs1_adr    = 5'd0;
        dif.dbg_req   = 1'b0;
        dif.dbg_we    = 1'b0;
        dif.dbg_addr  = 5'd0;
        dif.dbg_wdata = 32'd0;

        nxt();
        nxt();
        chk("rst_ack",   {31'd0, dif.dbg_ack},  32'd0);
        chk("rst_busy",  {31'd0, dif.dbg_busy}, 32'd0);
        chk("rst_stall", {31'd0, pipe_stall},   32'd0);
        chk("rst_rdata", dif.dbg_rdata,         32'd0);

        // Passthrough, applied while still in reset
        for (int i = 0; i < 5; i++) begin
            wb_regwrite = tbl[i].wbw;
            wb_rd       = tbl[i].rd;
            wb_data     = tbl[i].data;
            id_rs1_adr  = tbl[i].rs1;
            #1;
            chk($sformatf("tbl%0d_wen", i),   {31'd0, rf_wen},       {31'd0, tbl[i].exp_wen});
            chk($sformatf("tbl%0d_wadr", i),  {27'd0, rf_wadr},      {27'd0, tbl[i].exp_wadr});
            chk($sformatf("tbl%0d_wdata", i), rf_wdata,              tbl[i].exp_wdata);
            chk($sformatf("tbl%0d_rs1", i),   {27'd0, rf_rs1_adr},   {27'd0, tbl[i].exp_rs1});
        end

        Rst = 1'b0;
        wb_regwrite = 1'b0;
        id_rs1_adr  = 5'd2;
        nxt();

        // Write with an idle pipeline
        request(1'b1, 5'd5, 32'hDEAD_BEEF);
        chk("wi_wen",   {31'd0, rf_wen},      32'd1);
        chk("wi_wadr",  {27'd0, rf_wadr},     32'd5);
        chk("wi_wdata", rf_wdata,             32'hDEAD_BEEF);
        chk("wi_stall", {31'd0, pipe_stall},  32'd0);
        chk("wi_ack0",  {31'd0, dif.dbg_ack}, 32'd0);
        nxt();
        chk("wi_ack1",  {31'd0, dif.dbg_ack}, 32'd1);
        chk("wi_stall2",{31'd0, pipe_stall},  32'd0);
        chk("wi_wen2",  {31'd0, rf_wen},      32'd0);
        nxt();
        chk("wi_ack2",  {31'd0, dif.dbg_ack}, 32'd0);
        chk("wi_busy",  {31'd0, dif.dbg_busy},32'd0);

        // Write with a busy pipeline: 8 WAIT cycles, then STALL until writeback frees up
        wb_regwrite = 1'b1;
        wb_rd       = 5'd3;
        wb_data     = 32'hCAFE_0003;
        request(1'b1, 5'd9, 32'h0BAD_F00D);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wb_wait%0d_stall", i), {31'd0, pipe_stall}, 32'd0);
            chk($sformatf("wb_wait%0d_wen", i),   {31'd0, rf_wen},     32'd1);
            chk($sformatf("wb_wait%0d_wadr", i),  {27'd0, rf_wadr},    32'd3);
            chk($sformatf("wb_wait%0d_wdata", i), rf_wdata,            32'hCAFE_0003);
            nxt();
        end
        chk("wb_stall_in",   {31'd0, pipe_stall}, 32'd1);
        chk("wb_stall_wadr", {27'd0, rf_wadr},    32'd3);
        nxt();
        chk("wb_stall_hold", {31'd0, pipe_stall}, 32'd1);
        chk("wb_stall_wen",  {31'd0, rf_wen},     32'd1);
        wb_regwrite = 1'b0;
        #1;
        chk("wb_land_wen",   {31'd0, rf_wen},      32'd1);
        chk("wb_land_wadr",  {27'd0, rf_wadr},     32'd9);
        chk("wb_land_wdata", rf_wdata,             32'h0BAD_F00D);
        chk("wb_land_ack",   {31'd0, dif.dbg_ack}, 32'd0);
        nxt();
        chk("wb_ack",        {31'd0, dif.dbg_ack}, 32'd1);
        chk("wb_ack_stall",  {31'd0, pipe_stall},  32'd0);
        nxt();

        // Read of x7
        request(1'b0, 5'd7, 32'd0);
        chk("rd_stall",  {31'd0, pipe_stall},  32'd1);
        chk("rd_rs1",    {27'd0, rf_rs1_adr},  32'd7);
        chk("rd_ack0",   {31'd0, dif.dbg_ack}, 32'd0);
        nxt();
        chk("rd_ack",    {31'd0, dif.dbg_ack}, 32'd1);
        chk("rd_rdata",  dif.dbg_rdata,        32'h1234_5678);
        chk("rd_stall2", {31'd0, pipe_stall},  32'd0);
        chk("rd_rs1_2",  {27'd0, rf_rs1_adr},  32'd2);
        nxt();

        // Read of x0 returns zero
        request(1'b0, 5'd0, 32'd0);
        nxt();
        chk("r0_ack",   {31'd0, dif.dbg_ack}, 32'd1);
        chk("r0_rdata", dif.dbg_rdata,        32'd0);
        nxt();

        request(1'b0, 5'd7, 32'd0);
        nxt();
        chk("rd2_rdata", dif.dbg_rdata, 32'h1234_5678);
        nxt();

        // Write to x0: ack, no write enable, read data untouched
        request(1'b1, 5'd0, 32'h5555_5555);
        chk("w0_wen",   {31'd0, rf_wen},       32'd0);
        chk("w0_busy",  {31'd0, dif.dbg_busy}, 32'd1);
        nxt();
        chk("w0_ack",   {31'd0, dif.dbg_ack},  32'd1);
        chk("w0_rdata", dif.dbg_rdata,         32'h1234_5678);
        nxt();

        // Reset while a read sits in STALL
        wb_regwrite = 1'b1;
        wb_rd       = 5'd4;
        request(1'b0, 5'd7, 32'd0);
        chk("rs_stall0", {31'd0, pipe_stall}, 32'd1);
        nxt();
        chk("rs_stall1", {31'd0, pipe_stall},  32'd1);
        chk("rs_ack1",   {31'd0, dif.dbg_ack}, 32'd0);
        Rst = 1'b1;
        nxt();
        Rst = 1'b0;
        wb_regwrite = 1'b0;
        #1;
        chk("rs_stall",  {31'd0, pipe_stall},   32'd0);
        chk("rs_ack",    {31'd0, dif.dbg_ack},  32'd0);
        chk("rs_busy",   {31'd0, dif.dbg_busy}, 32'd0);
        chk("rs_rdata",  dif.dbg_rdata,         32'd0);
        chk("rs_wen",    {31'd0, rf_wen},       32'd0);
        nxt();
        chk("rs_ack_after", {31'd0, dif.dbg_ack}, 32'd0);

        // Back-to-back: request held across the ack
        exp_ack  = 5'b10010;
        exp_busy = 5'b11011;
        exp_wen  = 5'b01001;
        dif.dbg_req   = 1'b1;
        dif.dbg_we    = 1'b1;
        dif.dbg_addr  = 5'd10;
        dif.dbg_wdata = 32'h0000_0077;
        nxt();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bb%0d_ack", i),  {31'd0, dif.dbg_ack},  {31'd0, exp_ack[i]});
            chk($sformatf("bb%0d_busy", i), {31'd0, dif.dbg_busy}, {31'd0, exp_busy[i]});
            chk($sformatf("bb%0d_wen", i),  {31'd0, rf_wen},       {31'd0, exp_wen[i]});
            if (i == 3) dif.dbg_req = 1'b0;
            nxt();
        end
        chk("bb_end_busy", {31'd0, dif.dbg_busy}, 32'd0);
        chk("bb_end_ack",  {31'd0, dif.dbg_ack},  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Shares the register file's write port and rs1 read port between the pipeline (writeback and decode) and a debug/UART requester. Pipeline writeback always has priority on the write port. A debug write uses the first idle writeback slot. If no idle slot appears within a bounded wait, or the request is a read, the block stalls the pipeline to get access. It sits between MEM/WB, decode and the register file, alongside the UART debug logic.

## Interface
Parameters:
- STARVE_LIMIT, default 8: cycles a debug write may wait for a free writeback slot before forcing a stall; must be at least 1.

Ports (clock and reset first):
- clk  in  1  system clock
- Rst  in  1  reset, synchronous, active-high
- wb_regwrite  in  1  MEM/WB register write enable
- wb_rd  in  5  MEM/WB destination register
- wb_data  in  32  MEM/WB writeback result
- id_rs1_adr  in  5  decode rs1 address
- rf_rs1_data  in  32  register file rs1 read data (combinational)
- dbg_req  in  1  debug request
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  5  debug register address
- dbg_wdata  in  32  debug write data
- rf_wen  out  1  register file write enable
- rf_wadr  out  5  register file write address
- rf_wdata  out  32  register file write data
- rf_rs1_adr  out  5  register file rs1 address
- pipe_stall  out  1  freeze request to pipeline
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  32  read result, registered
- dbg_busy  out  1  request in progress (state ≠ IDLE)

## Operation
- States: IDLE, WAIT, STALL, RESP. A "free slot" means wb_regwrite == 0 or wb_rd == 0.
- IDLE:
  - dbg_req sampled high latches dbg_we, dbg_addr and dbg_wdata, and clears the counter.
  - Next state is WAIT for a write, STALL for a read.
  - dbg_req is ignored in every other state.
- WAIT (write only), pipe_stall = 0:
  - If the slot is free, drive the latched write this cycle and go to RESP.
  - Otherwise increment the counter. When the counter reaches STARVE_LIMIT-1, go to STALL.
- STALL, pipe_stall = 1:
  - For a read, rf_rs1_adr = latched address.
  - If the slot is free, a write is driven, or a read captures rf_rs1_data into dbg_rdata; then go to RESP.
  - Otherwise remain in STALL, since in-flight writeback drains first.
- RESP:
  - dbg_ack = 1 and pipe_stall = 0; go to IDLE.
  - A new request can be accepted on the following IDLE cycle.
- Write port mux:
  - In the cycle a debug write is performed: rf_wadr = latched address, rf_wdata = latched data, rf_wen = (latched address ≠ 0).
  - At all other times: rf_wadr = wb_rd, rf_wdata = wb_data, rf_wen = wb_regwrite && wb_rd ≠ 0.
  - A valid writeback is never dropped or delayed.
- rf_rs1_adr = id_rs1_adr except during a read in STALL.
- Register 0:
  - A write to x0 completes with an ack but no rf_wen.
  - A read of x0 returns 0.
- dbg_rdata holds its last value until the next read completes. Writes do not change it.
- The counter is sized to hold STARVE_LIMIT without overflow. It only counts in WAIT.

## Timing
- Reset (sampled on the clk edge): state IDLE, counter 0, dbg_ack 0, dbg_rdata 0, pipe_stall 0, dbg_busy 0.
- Reset mid-operation abandons the request: no ack, and no debug write after the reset edge.
- The write/rs1 mux paths are combinational, so passthrough continues during Rst.
- Write with a free slot: request sampled at edge k; write in cycle k+1; dbg_ack in cycle k+2.
- Read: pipe_stall is high from cycle k+1. dbg_rdata is captured at the end of the first free-slot STALL cycle and is valid when dbg_ack is high.
- Worst-case write: STARVE_LIMIT WAIT cycles, then stall until the writeback drains.
- pipe_stall is registered state: high only in STALL, and drops in RESP.
- If dbg_req is still high in the RESP cycle, it is sampled again in IDLE on the next edge as a new request.

## Test plan
- Write, idle pipeline: dbg_req, we=1, addr=5, wdata=0xDEADBEEF, wb_regwrite=0.
  - Required: rf_wen=1, rf_wadr=5, rf_wdata=0xDEADBEEF in cycle k+1.
  - Required: dbg_ack in k+2; pipe_stall never asserted.
- Write, busy pipeline: wb_regwrite=1, wb_rd=3 continuously, STARVE_LIMIT=8.
  - Required: STALL entered after 8 WAIT cycles; every wb write passes through.
  - Required: the debug write lands on the first cycle with wb_regwrite=0, with the ack one cycle later.
- Read: x7 holds 0x12345678; dbg_req, we=0, addr=7.
  - Required: pipe_stall=1 and rf_rs1_adr=7 in k+1.
  - Required: dbg_rdata=0x12345678 with dbg_ack in k+2; pipe_stall=0 in k+2.
- x0 handling:
  - Write to x0: ack arrives and rf_wen stays 0.
  - Read of x0: dbg_rdata=0.
- Reset in STALL: assert Rst while in STALL.
  - Required: next cycle is IDLE with pipe_stall=0, dbg_ack=0, dbg_rdata=0, and no debug write occurs.
- Back-to-back: dbg_req held high across the ack.
  - Required: the second request is accepted on the edge after RESP, and the two ack pulses are separated by at least one non-ack cycle.
